// File: rtl/pid_pkg.sv
// Shared definitions for the discrete PID datapath: FSM state encoding,
// default widths and the common saturation helper.
package pid_pkg;

    localparam int N_DEF    = 8;
    localparam int FRAC_DEF = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        MULT = 2'd2,
        OUT  = 2'd3
    } state_e;

    // Clamp a sign-extended value into the signed range of an n-bit word (n <= 63).
    function automatic logic signed [63:0] sat_n(input logic signed [63:0] value, input int n);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (n - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (n - 1));
        if (value > hi) begin
            sat_n = hi;
        end else if (value < lo) begin
            sat_n = lo;
        end else begin
            sat_n = value;
        end
    endfunction

endpackage

// File: rtl/sat_shift.sv
// Combinational floor-shift of the derivative product followed by clamping
// to the N-bit signed result range.
module sat_shift
    import pid_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int FRAC = FRAC_DEF
) (
    input  logic signed [2*N:0] prod_i,
    output logic signed [N-1:0] sat_o
);

    localparam logic signed [N-1:0] MAX_V = {1'b0, {(N-1){1'b1}}};
    localparam logic signed [N-1:0] MIN_V = {1'b1, {(N-1){1'b0}}};

    logic signed [2*N:0] shifted_s;
    logic signed [63:0]  wide_s;
    logic signed [63:0]  clamp_s;
    logic                sat_hi_s;
    logic                sat_lo_s;

    // Arithmetic shift gives floor rounding; flags pick the clamp rail.
    always_comb begin
        shifted_s = prod_i >>> FRAC;
        wide_s    = 64'(shifted_s);
        clamp_s   = sat_n(wide_s, N);
        sat_hi_s  = (wide_s > clamp_s);
        sat_lo_s  = (wide_s < clamp_s);
        if (sat_hi_s) begin
            sat_o = MAX_V;
        end else if (sat_lo_s) begin
            sat_o = MIN_V;
        end else begin
            sat_o = wide_s[N-1:0];
        end
    end

endmodule

// File: rtl/dk_term.sv
// Derivative-term engine: dk = sat(C*(yk - yk_1) >>> FRAC) with its own
// one-sample history, delivered over a valid/ready handshake.
module dk_term
    import pid_pkg::*;
#(
    parameter int                  N    = N_DEF,
    parameter logic signed [N-1:0] C    = 8'sd64,
    parameter int                  FRAC = FRAC_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic signed [N-1:0] yk,
    input  logic                in_valid,
    output logic                in_ready,
    output logic signed [N-1:0] dk,
    output logic                out_valid,
    input  logic                out_ready
);

    localparam int W = 2 * N + 1;

    state_e              state_q,     state_d;
    logic signed [N-1:0] yk_reg_q,    yk_reg_d;
    logic signed [N-1:0] yk_1_q,      yk_1_d;
    logic                first_q,     first_d;
    logic signed [N:0]   diff_q,      diff_d;
    logic signed [N-1:0] dk_q,        dk_d;
    logic                out_valid_q, out_valid_d;
    logic                in_ready_q,  in_ready_d;

    logic signed [N:0]   diff_s;
    logic signed [W-1:0] prod_s;
    logic signed [N-1:0] sat_s;

    always_comb begin
        diff_s = {yk_reg_q[N-1], yk_reg_q} - {yk_1_q[N-1], yk_1_q};
        prod_s = W'(diff_q) * W'(C);
    end

    sat_shift #(
        .N    (N),
        .FRAC (FRAC)
    ) u_sat_shift (
        .prod_i (prod_s),
        .sat_o  (sat_s)
    );

    // Transaction FSM and datapath next-state.
    always_comb begin
        state_d     = state_q;
        yk_reg_d    = yk_reg_q;
        diff_d      = diff_q;
        dk_d        = dk_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    yk_reg_d = yk;
                    state_d  = SUB;
                end else begin
                    state_d  = IDLE;
                end
            end
            SUB: begin
                diff_d  = first_q ? {(N + 1){1'b0}} : diff_s;
                state_d = MULT;
            end
            MULT: begin
                dk_d        = sat_s;
                out_valid_d = 1'b1;
                state_d     = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    state_d     = OUT;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
        in_ready_d = (state_d == IDLE);
    end

    // History: clear overrides the SUB update but never disturbs the result in flight.
    always_comb begin
        yk_1_d  = yk_1_q;
        first_d = first_q;
        if (clear) begin
            yk_1_d  = {N{1'b0}};
            first_d = 1'b1;
        end else if (state_q == SUB) begin
            yk_1_d  = yk_reg_q;
            first_d = 1'b0;
        end else begin
            yk_1_d  = yk_1_q;
            first_d = first_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            yk_reg_q    <= {N{1'b0}};
            yk_1_q      <= {N{1'b0}};
            first_q     <= 1'b1;
            diff_q      <= {(N + 1){1'b0}};
            dk_q        <= {N{1'b0}};
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            yk_reg_q    <= yk_reg_d;
            yk_1_q      <= yk_1_d;
            first_q     <= first_d;
            diff_q      <= diff_d;
            dk_q        <= dk_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign dk        = dk_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_dk_term.sv
// Randomized scoreboard bench for dk_term: two instances (C=64 and C=96) run
// in lockstep against a plain-arithmetic reference model.
module tb_dk_term;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              clear;
    logic signed [7:0] yk;
    logic              in_valid;
    logic              out_ready;
    logic              in_ready64, in_ready96;
    logic              out_valid64, out_valid96;
    logic signed [7:0] dk64, dk96;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rdy_mode = 0;

    int exp64_q[$];
    int exp96_q[$];
    int acc_q[$];
    int prev_y;
    bit first_m;

    dk_term #(.N(8), .C(8'sd64), .FRAC(6)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .yk(yk), .in_valid(in_valid),
        .in_ready(in_ready64), .dk(dk64), .out_valid(out_valid64), .out_ready(out_ready)
    );

    dk_term #(.N(8), .C(8'sd96), .FRAC(6)) u_dut96 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .yk(yk), .in_valid(in_valid),
        .in_ready(in_ready96), .dk(dk96), .out_valid(out_valid96), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: difference, scale, floor-divide by 2^6, clamp to 8 bits.
    function automatic int ref_dk(input int y, input int p, input bit f, input int c);
        int d;
        int prod;
        int q;
        d    = f ? 0 : (y - p);
        prod = d * c;
        q    = prod / 64;
        if ((prod % 64) != 0 && prod < 0) q = q - 1;
        if (q > 127) q = 127;
        if (q < -128) q = -128;
        return q;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic send(input int y);
        int waitc;
        @(posedge clk); #1;
        yk       = 8'(y);
        in_valid = 1'b1;
        waitc    = 0;
        @(negedge clk);
        while (!in_ready64 && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        if (!in_ready64) begin
            check("send_timeout", 0, 1);
        end else begin
            exp64_q.push_back(ref_dk(y, prev_y, first_m, 64));
            exp96_q.push_back(ref_dk(y, prev_y, first_m, 96));
            acc_q.push_back(cyc);
            prev_y  = y;
            first_m = 1'b0;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic model_clear();
        prev_y  = 0;
        first_m = 1'b1;
    endtask

    task automatic wait_drain();
        int waitc;
        waitc = 0;
        while ((exp64_q.size() != 0 || !in_ready64) && waitc < 100) begin
            @(negedge clk);
            waitc++;
        end
        if (exp64_q.size() != 0 || !in_ready64) check("drain_timeout", 0, 1);
    endtask

    // out_ready pattern: 0 = always ready, 1 = random, other = stalled.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #2;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pop on each new result, check stability while stalled.
    initial begin
        bit ov_prev;
        bit ordy_prev;
        int dk_prev;
        int e64, e96, a;
        ov_prev = 1'b0; ordy_prev = 1'b0; dk_prev = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                ov_prev = 1'b0;
                ordy_prev = 1'b0;
            end else begin
                if (out_valid64 !== out_valid96) check("lockstep_valid", int'(out_valid96), int'(out_valid64));
                if (ov_prev && !ordy_prev) begin
                    check("stall_valid", int'(out_valid64), 1);
                    check("stall_dk", int'(dk64), dk_prev);
                    check("stall_in_ready", int'(in_ready64), 0);
                end else if (ov_prev && ordy_prev) begin
                    check("post_hs_in_ready", int'(in_ready64), 1);
                end else if (out_valid64) begin
                    if (exp64_q.size() == 0) begin
                        check("unexpected_output", 1, 0);
                    end else begin
                        e64 = exp64_q.pop_front();
                        e96 = exp96_q.pop_front();
                        a   = acc_q.pop_front();
                        check("dk_c64", int'(dk64), e64);
                        check("dk_c96", int'(dk96), e96);
                        check("latency", cyc - a, 3);
                    end
                end
                ov_prev   = out_valid64;
                ordy_prev = out_ready;
                dk_prev   = int'(dk64);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        clear    = 1'b0;
        yk       = 8'sd0;
        in_valid = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", int'(in_ready64), 1);
        check("reset_out_valid", int'(out_valid64), 0);
        check("reset_dk", int'(dk64), 0);
        rst_n = 1'b1;

        // Unity gain and floor rounding (C=96 instance gives 0, 30, -2).
        send(10); send(30); send(29);
        wait_drain();

        // Saturation both ways.
        @(posedge clk); #1; clear = 1'b1; model_clear();
        @(posedge clk); #1; clear = 1'b0;
        send(127); send(-128); send(127);
        wait_drain();

        // Backpressure: hold out_ready low while OUT.
        rdy_mode = 2;
        send(5);
        repeat (8) @(posedge clk);
        #1; rdy_mode = 0;
        wait_drain();

        // Clear in IDLE.
        send(40); send(60);
        wait_drain();
        @(posedge clk); #1; clear = 1'b1; model_clear();
        @(posedge clk); #1; clear = 1'b0;
        send(70);
        wait_drain();

        // Clear during SUB of the 60 sample.
        send(40); send(60);
        clear = 1'b1; model_clear();
        @(posedge clk); #1; clear = 1'b0;
        send(80);
        wait_drain();

        // Reset while in MULT.
        send(50);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", int'(out_valid64), 0);
        check("midrst_dk", int'(dk64), 0);
        exp64_q.delete(); exp96_q.delete(); acc_q.delete();
        model_clear();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", int'(in_ready64), 1);
        send(20);
        wait_drain();

        // Randomized traffic with random backpressure and occasional clears.
        rdy_mode = 1;
        for (int i = 0; i < 200; i++) begin
            send(int'($urandom_range(0, 255)) - 128);
            if ($urandom_range(0, 15) == 0) begin
                clear = 1'b1; model_clear();
                @(posedge clk); #1; clear = 1'b0;
            end
        end
        @(posedge clk); #1; rdy_mode = 0;
        wait_drain();
        repeat (4) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
